// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - write/read handshake bundle for sync_fifo
interface sync_fifo_if #(
    parameter int WIDTH   = 8,
    parameter int POINTER = 4
);
    logic               wr_en;
    logic [WIDTH-1:0]   wr_data;
    logic               wr_full;
    logic               wr_afull;
    logic               wr_ovf;
    logic               rd_en;
    logic [WIDTH-1:0]   rd_data;
    logic               rd_valid;
    logic               rd_empty;
    logic               rd_aempty;
    logic               rd_udf;
    logic [POINTER:0]   level;

    // FIFO side
    modport slave (
        input  wr_en, wr_data, rd_en,
        output wr_full, wr_afull, wr_ovf,
        output rd_data, rd_valid, rd_empty, rd_aempty, rd_udf, level
    );

    // producer/consumer side
    modport master (
        output wr_en, wr_data, rd_en,
        input  wr_full, wr_afull, wr_ovf,
        input  rd_data, rd_valid, rd_empty, rd_aempty, rd_udf, level
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with level, almost flags, error pulses, FWFT/registered read
module sync_fifo #(
    parameter int WIDTH   = 8,
    parameter int POINTER = 4,
    parameter int AFULL   = 14,
    parameter int AEMPTY  = 2,
    parameter int FWFT    = 1
) (
    input  logic          clk,
    input  logic          srst,
    sync_fifo_if.slave    bus
);
    localparam int DEPTH = 1 << POINTER;

    localparam logic [POINTER:0] AFULL_L  = (POINTER+1)'(AFULL);
    localparam logic [POINTER:0] AEMPTY_L = (POINTER+1)'(AEMPTY);
    localparam logic [POINTER:0] ONE_L    = {{POINTER{1'b0}}, 1'b1};

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [POINTER:0]   r_wr_ptr;
    logic [POINTER:0]   r_rd_ptr;
    logic [POINTER:0]   r_level;
    logic               r_ovf;
    logic               r_udf;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_acc;
    logic               w_rd_acc;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the addresses coincide.
    assign w_full  = (r_wr_ptr[POINTER] != r_rd_ptr[POINTER]) &&
                     (r_wr_ptr[POINTER-1:0] == r_rd_ptr[POINTER-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // Acceptance only looks at registered full/empty, so a read on a full FIFO
    // never frees a slot for a write in the same cycle (and vice versa).
    assign w_wr_acc = bus.wr_en & ~w_full;
    assign w_rd_acc = bus.rd_en & ~w_empty;

    assign bus.wr_full   = w_full;
    assign bus.rd_empty  = w_empty;
    assign bus.wr_afull  = (r_level >= AFULL_L);
    assign bus.rd_aempty = (r_level <= AEMPTY_L);
    assign bus.wr_ovf    = r_ovf;
    assign bus.rd_udf    = r_udf;
    assign bus.level     = r_level;

    // Storage array: never reset, writes suppressed during reset
    always_ff @(posedge clk) begin
        if (!srst && w_wr_acc) begin
            r_mem[r_wr_ptr[POINTER-1:0]] <= bus.wr_data;
        end
    end

    // Pointer, level and error-pulse state
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ONE_L;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ONE_L;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + ONE_L;
                2'b01:   r_level <= r_level - ONE_L;
                default: r_level <= r_level;
            endcase
            r_ovf <= bus.wr_en & w_full;
            r_udf <= bus.rd_en & w_empty;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always presented; popping advances to the next one.
            assign bus.rd_data  = r_mem[r_rd_ptr[POINTER-1:0]];
            assign bus.rd_valid = ~w_empty;
        end else begin : g_reg_read
            logic [WIDTH-1:0] r_rd_data;
            logic             r_rd_valid;

            // Registered read: data lands one cycle after an accepted pop and
            // is held until the next pop.
            always_ff @(posedge clk) begin
                if (srst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_data <= r_mem[r_rd_ptr[POINTER-1:0]];
                    end
                end
            end

            assign bus.rd_data  = r_rd_data;
            assign bus.rd_valid = r_rd_valid;
        end
    endgenerate
endmodule
